// File: rtl/pad_pkg.sv
// Shared constants and helpers for the pad hit detector slice.
package pad_pkg;

  localparam int MAX_PADS  = 32;
  localparam int PAD_IDX_W = 5;

  // Presentation state encoding
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [PAD_IDX_W-1:0] lowest_set(input logic [MAX_PADS-1:0] vec);
    lowest_set = '0;
    for (int i = MAX_PADS - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = PAD_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/pad_debouncer.sv
// Synchronises the raw pad lines, samples them on a slow prescaler tick and
// only lets a level through once two consecutive samples agree.
module pad_debouncer
  import pad_pkg::*;
#(
  parameter int unsigned NUM_PADS = 24,
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned TICK_W   = 18
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_PADS-1:0] lines,
  output logic [NUM_PADS-1:0] stable
);

  logic [NUM_PADS-1:0] sync_a;
  logic [NUM_PADS-1:0] sync_b;
  logic [NUM_PADS-1:0] sample_cur;
  logic [TICK_W-1:0]   count;
  logic                tick;

  assign tick = (count == TICK_W'(TICK_DIV - 1));

  // Two-flop synchroniser against metastability on the asynchronous pads
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= lines;
      sync_b <= sync_a;
    end
  end

  // Free-running prescaler that wraps every TICK_DIV cycles
  always_ff @(posedge clock) begin
    if (reset) count <= '0;
    else if (tick) count <= '0;
    else count <= count + 1'b1;
  end

  // On each tick the old sample becomes the previous one; a pad's stable level
  // follows the new sample only where it agrees with the previous sample
  always_ff @(posedge clock) begin
    if (reset) begin
      sample_cur <= '0;
      stable     <= '0;
    end else if (tick) begin
      sample_cur <= sync_b;
      stable     <= (sync_b & ~(sync_b ^ sample_cur)) | (stable & (sync_b ^ sample_cur));
    end
  end

endmodule

// File: rtl/pad_hit_detector.sv
// Conditions the pad sensor lines, queues rising edges as pending hits, scores
// each against the lit target and hands them out one at a time.
module pad_hit_detector
  import pad_pkg::*;
#(
  parameter int unsigned NUM_PADS = 24,
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned TICK_W   = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [MAX_PADS-1:0]  sensor_input,
  input  logic [PAD_IDX_W-1:0] target_pad,
  input  logic                 target_valid,
  input  logic                 hit_ack,
  output logic [MAX_PADS-1:0]  pads_stable,
  output logic                 hit_valid,
  output logic [PAD_IDX_W-1:0] hit_pad,
  output logic                 hit_correct,
  output logic                 mistake,
  output logic                 overflow
);

  logic [NUM_PADS-1:0]  stable_n;
  logic [MAX_PADS-1:0]  stable;
  logic [MAX_PADS-1:0]  stable_d;
  logic [MAX_PADS-1:0]  rise;
  logic [MAX_PADS-1:0]  pending;
  logic [MAX_PADS-1:0]  correct;
  logic [MAX_PADS-1:0]  match_mask;
  logic [MAX_PADS-1:0]  clear_mask;
  logic [MAX_PADS-1:0]  new_mask;
  logic [0:0]           state;
  logic [PAD_IDX_W-1:0] hit_pad_q;
  logic                 unused_sensor;

  assign unused_sensor = ^sensor_input;

  pad_debouncer #(
    .NUM_PADS (NUM_PADS),
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_debouncer (
    .clock  (clock),
    .reset  (reset),
    .lines  (sensor_input[NUM_PADS-1:0]),
    .stable (stable_n)
  );

  // Widen debounced levels, find edges, and work out which pads are newly
  // captured; the acked pad counts as free so a re-press in its ack cycle wins
  always_comb begin
    stable = '0;
    stable[NUM_PADS-1:0] = stable_n;
    rise = stable & ~stable_d;
    match_mask = '0;
    if (32'(target_pad) < NUM_PADS) match_mask[target_pad] = 1'b1;
    clear_mask = '0;
    if (state == ST_PRESENT && hit_ack) clear_mask[hit_pad_q] = 1'b1;
    new_mask = rise & ~(pending & ~clear_mask);
  end

  // Pending/correct bookkeeping, sticky overflow and the mistake pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      stable_d <= '0;
      pending  <= '0;
      correct  <= '0;
      overflow <= 1'b0;
      mistake  <= 1'b0;
    end else begin
      stable_d <= stable;
      pending  <= (pending & ~clear_mask) | rise;
      correct  <= (correct & ~new_mask) | (new_mask & (target_valid ? match_mask : '0));
      overflow <= overflow | (|(rise & pending & ~clear_mask));
      mistake  <= target_valid && (|(new_mask & ~match_mask));
    end
  end

  // Presentation handshake: latch the lowest pending pad, hold it until acked
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      hit_pad_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending != '0) begin
            state     <= ST_PRESENT;
            hit_pad_q <= lowest_set(pending);
          end
        end
        default: begin
          if (hit_ack) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pads_stable = stable;
  assign hit_valid   = (state == ST_PRESENT);
  assign hit_pad     = hit_pad_q;
  assign hit_correct = hit_valid & correct[hit_pad_q];

endmodule

// File: tb/tb_pad_hit_detector.sv
// Directed bench for pad_hit_detector with a short debounce tick.
module tb_pad_hit_detector;

  logic        clock;
  logic        reset;
  logic [31:0] sensorInput;
  logic [4:0]  targetPad;
  logic        targetValid;
  logic        hitAck;
  logic [31:0] padsStable;
  logic        hitValid;
  logic [4:0]  hitPad;
  logic        hitCorrect;
  logic        mistake;
  logic        overflow;

  int testCount = 0;
  int failCount = 0;
  int validCycles = 0;
  int mistakePulses = 0;
  int snapValid;
  int snapMistake;

  pad_hit_detector #(
    .NUM_PADS (24),
    .TICK_DIV (4),
    .TICK_W   (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sensor_input (sensorInput),
    .target_pad   (targetPad),
    .target_valid (targetValid),
    .hit_ack      (hitAck),
    .pads_stable  (padsStable),
    .hit_valid    (hitValid),
    .hit_pad      (hitPad),
    .hit_correct  (hitCorrect),
    .mistake      (mistake),
    .overflow     (overflow)
  );

  // 100 MHz-style free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count presented cycles and mistake pulses away from the active edge
  always @(negedge clock) begin
    if (hitValid === 1'b1) validCycles++;
    if (mistake === 1'b1) mistakePulses++;
  end

  // Hard stop in case anything unexpected stalls the sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] sens, input logic [4:0] tpad,
                               input logic tvalid, input logic ack);
    sensorInput = sens;
    targetPad   = tpad;
    targetValid = tvalid;
    hitAck      = ack;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitValid(input string tag, input int budget);
    int n = 0;
    while (hitValid !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    checkOutput(tag, {31'b0, hitValid}, 32'd1);
  endtask

  task automatic waitStable(input string tag, input int idx, input logic level,
                            input int budget);
    int n = 0;
    while (padsStable[idx] !== level && n < budget) begin
      step(1);
      n++;
    end
    checkOutput(tag, {31'b0, padsStable[idx]}, {31'b0, level});
  endtask

  task automatic ackHit();
    hitAck = 1'b1;
    step(1);
    hitAck = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(32'h0, 5'd0, 1'b0, 1'b0);
    step(3);
    checkOutput("rst_stable", padsStable, 32'h0);
    checkOutput("rst_valid", {31'b0, hitValid}, 32'd0);
    checkOutput("rst_pad", {27'b0, hitPad}, 32'd0);
    checkOutput("rst_correct", {31'b0, hitCorrect}, 32'd0);
    checkOutput("rst_mistake", {31'b0, mistake}, 32'd0);
    checkOutput("rst_overflow", {31'b0, overflow}, 32'd0);
    reset = 1'b0;

    // Idle with quiet pads
    snapValid = validCycles;
    step(50);
    checkOutput("idle_valid_cycles", 32'(validCycles - snapValid), 32'd0);
    checkOutput("idle_stable", padsStable, 32'h0);
    checkOutput("idle_overflow", {31'b0, overflow}, 32'd0);

    // Correct hit on pad 3
    snapMistake = mistakePulses;
    applyStimulus(32'h0000_0008, 5'd3, 1'b1, 1'b0);
    waitStable("p3_stable_latency", 3, 1'b1, 10);
    waitValid("p3_valid", 4);
    checkOutput("p3_pad", {27'b0, hitPad}, 32'd3);
    checkOutput("p3_correct", {31'b0, hitCorrect}, 32'd1);
    step(3);
    checkOutput("p3_held_valid", {31'b0, hitValid}, 32'd1);
    checkOutput("p3_held_pad", {27'b0, hitPad}, 32'd3);
    ackHit();
    checkOutput("p3_ack_drop", {31'b0, hitValid}, 32'd0);
    snapValid = validCycles;
    step(4);
    checkOutput("p3_no_repeat", 32'(validCycles - snapValid), 32'd0);
    checkOutput("p3_no_mistake", 32'(mistakePulses - snapMistake), 32'd0);

    // Short glitch on pad 5 must be filtered
    sensorInput[5] = 1'b1;
    step(2);
    sensorInput[5] = 1'b0;
    step(20);
    checkOutput("glitch_stable", padsStable, 32'h0000_0008);
    checkOutput("glitch_no_hit", 32'(validCycles - snapValid), 32'd0);

    // Pads 2 and 7 together, target 7: one mistake, pad 2 first
    snapMistake = mistakePulses;
    applyStimulus(32'h0000_008C, 5'd7, 1'b1, 1'b0);
    waitValid("dual_valid1", 16);
    checkOutput("dual_pad1", {27'b0, hitPad}, 32'd2);
    checkOutput("dual_correct1", {31'b0, hitCorrect}, 32'd0);
    checkOutput("dual_mistake", 32'(mistakePulses - snapMistake), 32'd1);
    ackHit();
    checkOutput("dual_gap", {31'b0, hitValid}, 32'd0);
    step(1);
    checkOutput("dual_valid2", {31'b0, hitValid}, 32'd1);
    checkOutput("dual_pad2", {27'b0, hitPad}, 32'd7);
    checkOutput("dual_correct2", {31'b0, hitCorrect}, 32'd1);
    ackHit();
    step(2);
    checkOutput("dual_mistake_once", 32'(mistakePulses - snapMistake), 32'd1);

    // Pad 4 re-pressed while still pending: overflow, single delivery
    snapMistake = mistakePulses;
    applyStimulus(32'h0000_009C, 5'd7, 1'b0, 1'b0);
    waitValid("ovf_valid", 16);
    checkOutput("ovf_pad", {27'b0, hitPad}, 32'd4);
    checkOutput("ovf_before", {31'b0, overflow}, 32'd0);
    sensorInput[4] = 1'b0;
    waitStable("ovf_release", 4, 1'b0, 12);
    sensorInput[4] = 1'b1;
    waitStable("ovf_repress", 4, 1'b1, 12);
    step(2);
    checkOutput("ovf_set", {31'b0, overflow}, 32'd1);
    checkOutput("ovf_still_pad", {27'b0, hitPad}, 32'd4);
    ackHit();
    checkOutput("ovf_ack_drop", {31'b0, hitValid}, 32'd0);
    snapValid = validCycles;
    step(4);
    checkOutput("ovf_single", 32'(validCycles - snapValid), 32'd0);
    checkOutput("ovf_sticky", {31'b0, overflow}, 32'd1);
    checkOutput("ovf_no_mistake", 32'(mistakePulses - snapMistake), 32'd0);

    // Reset mid-handshake with pads 1 and 9 pending
    sensorInput = sensorInput | 32'h0000_0202;
    waitValid("rstmid_valid", 16);
    checkOutput("rstmid_pad", {27'b0, hitPad}, 32'd1);
    reset = 1'b1;
    sensorInput = 32'h0;
    step(1);
    checkOutput("rstmid_stable", padsStable, 32'h0);
    checkOutput("rstmid_valid", {31'b0, hitValid}, 32'd0);
    checkOutput("rstmid_overflow", {31'b0, overflow}, 32'd0);
    checkOutput("rstmid_pad0", {27'b0, hitPad}, 32'd0);
    step(2);
    reset = 1'b0;
    snapValid = validCycles;
    step(30);
    checkOutput("rstmid_no_stale", 32'(validCycles - snapValid), 32'd0);
    sensorInput = 32'h0000_0200;
    waitValid("rstmid_new_valid", 16);
    checkOutput("rstmid_new_pad", {27'b0, hitPad}, 32'd9);
    ackHit();

    // Out-of-range target never matches
    snapMistake = mistakePulses;
    applyStimulus(32'h0000_0201, 5'd30, 1'b1, 1'b0);
    waitValid("oor_valid", 16);
    checkOutput("oor_pad", {27'b0, hitPad}, 32'd0);
    checkOutput("oor_correct", {31'b0, hitCorrect}, 32'd0);
    checkOutput("oor_mistake", 32'(mistakePulses - snapMistake), 32'd1);
    ackHit();
    step(2);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
